// File: rtl/zap_wb_merger.sv
// Two-master (code/data) to one-slave Wishbone merger. Arbitrates the caches'
// combinational *_nxt buses, registers the winner and routes ACK back to its owner.
module zap_wb_merger #(
  parameter int ROUND_ROBIN = 1,
  parameter int DATA_W      = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,

  input  logic                i_c_wb_cyc_nxt,
  input  logic                i_c_wb_stb_nxt,
  input  logic                i_c_wb_wen_nxt,
  input  logic [DATA_W/8-1:0] i_c_wb_sel_nxt,
  input  logic [31:0]         i_c_wb_adr_nxt,
  input  logic [DATA_W-1:0]   i_c_wb_dat_nxt,
  input  logic [2:0]          i_c_wb_cti_nxt,
  output logic                o_c_wb_ack,

  input  logic                i_d_wb_cyc_nxt,
  input  logic                i_d_wb_stb_nxt,
  input  logic                i_d_wb_wen_nxt,
  input  logic [DATA_W/8-1:0] i_d_wb_sel_nxt,
  input  logic [31:0]         i_d_wb_adr_nxt,
  input  logic [DATA_W-1:0]   i_d_wb_dat_nxt,
  input  logic [2:0]          i_d_wb_cti_nxt,
  output logic                o_d_wb_ack,

  output logic [DATA_W-1:0]   o_wb_dat_rd,

  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_wen,
  output logic [DATA_W/8-1:0] o_wb_sel,
  output logic [31:0]         o_wb_adr,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic [2:0]          o_wb_cti,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_ack,

  output logic                o_owner
);

  // owner/last encoding: 0 = code, 1 = data
  logic owner_ff;
  logic last_ff;
  logic owner_nxt;
  logic owner_cyc_nxt;
  logic arb;
  logic any_req;

  always_comb begin
    owner_cyc_nxt = owner_ff ? i_d_wb_cyc_nxt : i_c_wb_cyc_nxt;
    // Ownership may only move once the current beat is done and the owner has released cyc.
    arb           = (!o_wb_stb || i_wb_ack) && (!o_wb_cyc || !owner_cyc_nxt);
    any_req       = i_c_wb_cyc_nxt || i_d_wb_cyc_nxt;
    owner_nxt     = owner_ff;
    if (arb) begin
      if (i_c_wb_cyc_nxt && i_d_wb_cyc_nxt)
        owner_nxt = (ROUND_ROBIN != 0) ? ~last_ff : 1'b1;
      else if (i_d_wb_cyc_nxt)
        owner_nxt = 1'b1;
      else if (i_c_wb_cyc_nxt)
        owner_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_ff <= 1'b0;
      last_ff  <= 1'b1;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_wen <= 1'b0;
      o_wb_sel <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_cti <= 3'b000;
    end else begin
      owner_ff <= owner_nxt;
      if (arb && any_req)
        last_ff <= owner_nxt;
      if (owner_nxt) begin
        o_wb_cyc <= i_d_wb_cyc_nxt;
        o_wb_stb <= i_d_wb_stb_nxt;
        o_wb_wen <= i_d_wb_wen_nxt;
        o_wb_sel <= i_d_wb_sel_nxt;
        o_wb_adr <= i_d_wb_adr_nxt;
        o_wb_dat <= i_d_wb_dat_nxt;
        o_wb_cti <= i_d_wb_cti_nxt;
      end else begin
        o_wb_cyc <= i_c_wb_cyc_nxt;
        o_wb_stb <= i_c_wb_stb_nxt;
        o_wb_wen <= i_c_wb_wen_nxt;
        o_wb_sel <= i_c_wb_sel_nxt;
        o_wb_adr <= i_c_wb_adr_nxt;
        o_wb_dat <= i_c_wb_dat_nxt;
        o_wb_cti <= i_c_wb_cti_nxt;
      end
    end
  end

  // ACKs seen while no strobe is outstanding are dropped.
  assign o_c_wb_ack  = i_wb_ack && o_wb_stb && !owner_ff;
  assign o_d_wb_ack  = i_wb_ack && o_wb_stb &&  owner_ff;
  assign o_wb_dat_rd = i_wb_dat;
  assign o_owner     = owner_ff;

endmodule

// File: tb/tb_zap_wb_merger.sv
// Directed bench for zap_wb_merger: a round-robin instance and a fixed-priority
// instance share the master/slave stimulus; each step is checked against hand values.
module tb_zap_wb_merger;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        c_cyc, c_stb, c_wen;
  logic [3:0]  c_sel;
  logic [31:0] c_adr, c_dat;
  logic [2:0]  c_cti;
  logic        d_cyc, d_stb, d_wen;
  logic [3:0]  d_sel;
  logic [31:0] d_adr, d_dat;
  logic [2:0]  d_cti;
  logic [31:0] wb_dat_in;
  logic        wb_ack_in;

  logic        c_ack, d_ack, wb_cyc, wb_stb, wb_wen, owner;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat, dat_rd;
  logic [2:0]  wb_cti;

  logic        f_c_ack, f_d_ack, f_wb_cyc, f_wb_stb, f_wb_wen, f_owner;
  logic [3:0]  f_wb_sel;
  logic [31:0] f_wb_adr, f_wb_dat, f_dat_rd;
  logic [2:0]  f_wb_cti;

  int n_chk  = 0;
  int n_pass = 0;
  int d_ack_cnt;

  always #5 i_clk = ~i_clk;

  zap_wb_merger #(.ROUND_ROBIN(1), .DATA_W(32)) dut_rr (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_wen_nxt(c_wen),
    .i_c_wb_sel_nxt(c_sel), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
    .i_c_wb_cti_nxt(c_cti), .o_c_wb_ack(c_ack),
    .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_stb_nxt(d_stb), .i_d_wb_wen_nxt(d_wen),
    .i_d_wb_sel_nxt(d_sel), .i_d_wb_adr_nxt(d_adr), .i_d_wb_dat_nxt(d_dat),
    .i_d_wb_cti_nxt(d_cti), .o_d_wb_ack(d_ack),
    .o_wb_dat_rd(dat_rd),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_cti(wb_cti),
    .i_wb_dat(wb_dat_in), .i_wb_ack(wb_ack_in),
    .o_owner(owner)
  );

  zap_wb_merger #(.ROUND_ROBIN(0), .DATA_W(32)) dut_fp (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_wen_nxt(c_wen),
    .i_c_wb_sel_nxt(c_sel), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
    .i_c_wb_cti_nxt(c_cti), .o_c_wb_ack(f_c_ack),
    .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_stb_nxt(d_stb), .i_d_wb_wen_nxt(d_wen),
    .i_d_wb_sel_nxt(d_sel), .i_d_wb_adr_nxt(d_adr), .i_d_wb_dat_nxt(d_dat),
    .i_d_wb_cti_nxt(d_cti), .o_d_wb_ack(f_d_ack),
    .o_wb_dat_rd(f_dat_rd),
    .o_wb_cyc(f_wb_cyc), .o_wb_stb(f_wb_stb), .o_wb_wen(f_wb_wen), .o_wb_sel(f_wb_sel),
    .o_wb_adr(f_wb_adr), .o_wb_dat(f_wb_dat), .o_wb_cti(f_wb_cti),
    .i_wb_dat(wb_dat_in), .i_wb_ack(wb_ack_in),
    .o_owner(f_owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_c(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    c_cyc = cyc;
    c_stb = cyc;
    c_wen = 1'b0;
    c_sel = cyc ? 4'hF : 4'h0;
    c_adr = cyc ? adr : 32'h0;
    c_dat = 32'h0;
    c_cti = cyc ? cti : 3'b000;
  endtask

  task automatic set_d(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    d_cyc = cyc;
    d_stb = cyc;
    d_wen = cyc;
    d_sel = cyc ? 4'hF : 4'h0;
    d_adr = cyc ? adr : 32'h0;
    d_dat = cyc ? adr + 32'h1 : 32'h0;
    d_cti = cyc ? cti : 3'b000;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_c(1'b0, 32'h0, 3'b000);
    set_d(1'b0, 32'h0, 3'b000);
    wb_ack_in = 1'b0;
    wb_dat_in = 32'hCAFE_F00D;

    // Reset state
    do_reset();
    #1;
    chk("rst_cyc",   32'(wb_cyc), 32'h0);
    chk("rst_stb",   32'(wb_stb), 32'h0);
    chk("rst_adr",   wb_adr,      32'h0);
    chk("rst_cti",   32'(wb_cti), 32'h0);
    chk("rst_owner", 32'(owner),  32'h0);
    chk("dat_rd",    dat_rd,      32'hCAFE_F00D);

    // Code-only single read with two wait states
    set_c(1'b1, 32'h100, 3'b000);
    step();
    chk("c1_adr",  wb_adr,      32'h100);
    chk("c1_cyc",  32'(wb_cyc), 32'h1);
    chk("c1_ack0", 32'(c_ack),  32'h0);
    step();
    chk("c1_hold", wb_adr,      32'h100);
    chk("c1_ack1", 32'(c_ack),  32'h0);
    step();
    wb_ack_in = 1'b1;
    set_c(1'b0, 32'h0, 3'b000);
    #1;
    chk("c1_cack", 32'(c_ack), 32'h1);
    chk("c1_dack", 32'(d_ack), 32'h0);
    step();
    wb_ack_in = 1'b0;
    #1;
    chk("c1_idle", 32'(wb_cyc), 32'h0);
    chk("c1_ack3", 32'(c_ack),  32'h0);

    // Simultaneous requests after reset: RR serves code, FP serves data
    do_reset();
    set_c(1'b1, 32'h200, 3'b000);
    set_d(1'b1, 32'h300, 3'b000);
    step();
    chk("tie1_owner",   32'(owner),   32'h0);
    chk("tie1_adr",     wb_adr,       32'h200);
    chk("tie1_f_owner", 32'(f_owner), 32'h1);
    chk("tie1_f_adr",   f_wb_adr,     32'h300);
    wb_ack_in = 1'b1;
    set_c(1'b0, 32'h0, 3'b000);
    #1;
    chk("tie1_cack", 32'(c_ack), 32'h1);
    chk("tie1_dack", 32'(d_ack), 32'h0);
    step();
    wb_ack_in = 1'b0;
    #1;
    chk("b2b_owner", 32'(owner),  32'h1);
    chk("b2b_adr",   wb_adr,      32'h300);
    chk("b2b_wen",   32'(wb_wen), 32'h1);
    chk("b2b_dat",   wb_dat,      32'h301);
    wb_ack_in = 1'b1;
    set_d(1'b0, 32'h0, 3'b000);
    #1;
    chk("b2b_dack", 32'(d_ack), 32'h1);
    chk("b2b_cack", 32'(c_ack), 32'h0);
    step();
    // Spurious ACK on an idle bus
    #1;
    chk("spur_cack", 32'(c_ack),  32'h0);
    chk("spur_dack", 32'(d_ack),  32'h0);
    chk("spur_cyc",  32'(wb_cyc), 32'h0);
    step();
    wb_ack_in = 1'b0;
    chk("spur_owner", 32'(owner), 32'h1);
    set_c(1'b1, 32'h204, 3'b000);
    set_d(1'b1, 32'h304, 3'b000);
    step();
    chk("tie2_owner", 32'(owner), 32'h0);
    chk("tie2_adr",   wb_adr,     32'h204);
    wb_ack_in = 1'b1;
    set_c(1'b0, 32'h0, 3'b000);
    set_d(1'b0, 32'h0, 3'b000);
    #1;
    chk("tie2_cack", 32'(c_ack), 32'h1);
    step();
    wb_ack_in = 1'b0;

    // Data 8-beat incrementing burst, code requests from beat 2
    set_d(1'b1, 32'h400, 3'b010);
    step();
    d_ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wb_ack_in = 1'b1;
      if (i < 7) set_d(1'b1, 32'h400 + 32'(4 * (i + 1)), (i == 6) ? 3'b111 : 3'b010);
      else       set_d(1'b0, 32'h0, 3'b000);
      if (i >= 2) set_c(1'b1, 32'h500, 3'b000);
      #1;
      chk("burst_adr",   wb_adr,      32'h400 + 32'(4 * i));
      chk("burst_cti",   32'(wb_cti), (i == 7) ? 32'h7 : 32'h2);
      chk("burst_owner", 32'(owner),  32'h1);
      chk("burst_cack",  32'(c_ack),  32'h0);
      if (d_ack) d_ack_cnt++;
      step();
    end
    wb_ack_in = 1'b0;
    #1;
    chk("burst_dacks", 32'(d_ack_cnt), 32'd8);
    chk("sw_owner",    32'(owner),     32'h0);
    chk("sw_adr",      wb_adr,         32'h500);
    wb_ack_in = 1'b1;
    set_c(1'b0, 32'h0, 3'b000);
    #1;
    chk("sw_cack", 32'(c_ack), 32'h1);
    step();
    wb_ack_in = 1'b0;

    // Fixed priority: four data transactions while code keeps requesting
    do_reset();
    set_c(1'b1, 32'h700, 3'b000);
    set_d(1'b1, 32'h600, 3'b000);
    step();
    chk("fp_owner0", 32'(f_owner), 32'h1);
    chk("rr_owner0", 32'(owner),   32'h0);
    for (int k = 0; k < 4; k++) begin
      wb_ack_in = 1'b1;
      if (k < 3) set_d(1'b1, 32'h600 + 32'(4 * (k + 1)), 3'b000);
      else       set_d(1'b0, 32'h0, 3'b000);
      #1;
      chk("fp_adr",  f_wb_adr,     32'h600 + 32'(4 * k));
      chk("fp_dack", 32'(f_d_ack), 32'h1);
      chk("fp_cack", 32'(f_c_ack), 32'h0);
      step();
    end
    wb_ack_in = 1'b0;
    #1;
    chk("fp_code_owner", 32'(f_owner), 32'h0);
    chk("fp_code_adr",   f_wb_adr,     32'h700);
    wb_ack_in = 1'b1;
    set_c(1'b0, 32'h0, 3'b000);
    #1;
    chk("fp_code_ack", 32'(f_c_ack), 32'h1);
    step();
    wb_ack_in = 1'b0;

    // Reset asserted on beat 3 of a data burst
    do_reset();
    set_d(1'b1, 32'h800, 3'b010);
    step();
    for (int i = 0; i < 3; i++) begin
      wb_ack_in = 1'b1;
      set_d(1'b1, 32'h800 + 32'(4 * (i + 1)), 3'b010);
      step();
    end
    wb_ack_in = 1'b0;
    #1;
    chk("mid_beat3", wb_adr,     32'h80C);
    chk("mid_owner", 32'(owner), 32'h1);
    i_reset = 1'b1;
    step();
    chk("mid_rst_cyc",   32'(wb_cyc), 32'h0);
    chk("mid_rst_cti",   32'(wb_cti), 32'h0);
    chk("mid_rst_owner", 32'(owner),  32'h0);
    chk("mid_rst_dack",  32'(d_ack),  32'h0);
    i_reset = 1'b0;
    set_c(1'b1, 32'hA00, 3'b000);
    set_d(1'b1, 32'hB00, 3'b000);
    step();
    chk("post_tie_owner", 32'(owner), 32'h0);
    chk("post_tie_adr",   wb_adr,     32'hA00);
    set_c(1'b0, 32'h0, 3'b000);
    set_d(1'b0, 32'h0, 3'b000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
